// File: rtl/formula_chk_pkg.sv
// Shared types and constants for the formula sweep checker.
// No logic of its own; the LFSR tap helper is evaluated at elaboration time.
// No flow control; constants only.
package formula_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

    localparam int DEF_N_IN       = 31;
    localparam int DEF_SAMPLE_LAT = 1;
    localparam int DEF_CNT_W      = 32;
    localparam int SAMPLE_LAT_MAX = 8;

    // Fibonacci tap mask: bit (t-1) set for tap t, i.e. x^31 + x^28 + 1
    localparam logic [30:0] LFSR_TAPS_31 = 31'h4800_0000;

    // Tap mask for a given vector width. Widths listed are maximal-length;
    // anything else falls back to the top two bits (not maximal).
    function automatic logic [63:0] lfsr_taps(input int n);
        logic [63:0] t;
        case (n)
            3:       t = 64'h6;
            4:       t = 64'hC;
            5:       t = 64'h14;
            6:       t = 64'h30;
            7:       t = 64'h60;
            8:       t = 64'hB8;
            31:      t = {33'd0, LFSR_TAPS_31};
            default: t = (64'd1 << (n - 1)) | (64'd1 << (n - 2));
        endcase
        return t;
    endfunction

endpackage

// File: rtl/chk_stim_gen.sv
// Assignment generator: binary counter or Fibonacci LFSR over N_IN bits.
// Latency: load/step take effect on vec at the next clock edge.
// No backpressure; the caller decides when to step.
module chk_stim_gen
    import formula_chk_pkg::*;
#(
    parameter int N_IN = DEF_N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            mode,
    input  logic [N_IN-1:0] seed,
    output logic [N_IN-1:0] vec
);

    localparam logic [N_IN-1:0] TAPS = N_IN'(lfsr_taps(N_IN));

    logic mode_q;
    logic fb;

    // Feedback bit is the parity of the tapped state bits
    always_comb begin
        fb = ^(vec & TAPS);
    end

    // Load picks the mode and start point; step advances by one assignment
    always_ff @(posedge clk) begin
        if (rst) begin
            vec    <= '0;
            mode_q <= 1'b0;
        end else if (load) begin
            mode_q <= mode;
            if (mode) begin
                // An all-zero seed would lock the LFSR, so substitute 1
                vec <= (seed == '0) ? N_IN'(1) : seed;
            end else begin
                vec <= '0;
            end
        end else if (step) begin
            vec <= mode_q ? {vec[N_IN-2:0], fb} : vec + N_IN'(1);
        end
    end

endmodule

// File: rtl/formula_sweep_checker.sv
// Drives a combinational formula with a sweep of assignments and counts outputs of 0.
// Latency: f_out sampled SAMPLE_LAT-1 cycles after its assignment; counters one cycle later.
// No backpressure; one assignment per RUN cycle, abort stops issue and drains in-flight tags.
module formula_sweep_checker
    import formula_chk_pkg::*;
#(
    parameter int N_IN       = DEF_N_IN,
    parameter int SAMPLE_LAT = DEF_SAMPLE_LAT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             lfsr_mode,
    input  logic [N_IN-1:0]  seed,
    input  logic [CNT_W-1:0] iter_limit,
    output logic [N_IN-1:0]  vec_out,
    input  logic             f_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             aborted,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] checked_count,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic             first_fail_valid
);

    chk_state_t       state, state_nxt;
    logic [CNT_W-1:0] limit_q;
    logic [CNT_W-1:0] issued_q;
    logic             accept;
    logic             issue_vld;
    logic             last_issue;
    logic             samp_vld;
    logic [N_IN-1:0]  samp_vec;
    logic             pipe_busy;
    logic             samp_vld_q;
    logic             samp_f_q;
    logic [N_IN-1:0]  samp_vec_q;

    assign accept     = start && ((state == IDLE) || (state == DONE));
    assign issue_vld  = (state == RUN) && !abort;
    assign last_issue = issue_vld && ((issued_q + CNT_W'(1)) == limit_q);

    chk_stim_gen #(.N_IN(N_IN)) u_gen (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .step (issue_vld),
        .mode (lfsr_mode),
        .seed (seed),
        .vec  (vec_out)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and status outputs; abort beats start since start is only seen outside RUN
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        pass      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (abort || last_issue) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!pipe_busy) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                pass = (fail_count == '0) && !aborted;
                if (start) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep bookkeeping: effective length (0 means a full 2^N_IN) and issue count
    always_ff @(posedge clk) begin
        if (rst) begin
            limit_q  <= '0;
            issued_q <= '0;
            aborted  <= 1'b0;
        end else if (accept) begin
            limit_q  <= (iter_limit == '0) ? (CNT_W'(1) << N_IN) : iter_limit;
            issued_q <= '0;
            aborted  <= 1'b0;
        end else begin
            if (issue_vld)              issued_q <= issued_q + CNT_W'(1);
            if ((state == RUN) && abort) aborted <= 1'b1;
        end
    end

    // Tag line: an issued assignment reaches the sample point SAMPLE_LAT-1 cycles later
    if (SAMPLE_LAT == 1) begin : g_direct
        assign samp_vld  = issue_vld;
        assign samp_vec  = vec_out;
        assign pipe_busy = 1'b0;
    end else begin : g_line
        logic [SAMPLE_LAT-2:0] dly_vld;
        logic [N_IN-1:0]       dly_vec [SAMPLE_LAT-1];

        // Shift valid tags and their vectors toward the sample point
        always_ff @(posedge clk) begin
            if (rst) dly_vld <= '0;
            else     dly_vld <= (dly_vld << 1) | (SAMPLE_LAT-1)'(issue_vld);
            dly_vec[0] <= vec_out;
            for (int j = 1; j < SAMPLE_LAT - 1; j++) begin
                dly_vec[j] <= dly_vec[j-1];
            end
        end

        assign samp_vld  = dly_vld[SAMPLE_LAT-2];
        assign samp_vec  = dly_vec[SAMPLE_LAT-2];
        assign pipe_busy = |dly_vld;
    end

    // Capture f_out with its tag at the sample edge
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_vld_q <= 1'b0;
            samp_f_q   <= 1'b0;
            samp_vec_q <= '0;
        end else begin
            samp_vld_q <= samp_vld;
            samp_f_q   <= f_out;
            samp_vec_q <= samp_vec;
        end
    end

    // Result counters and first-failure capture, one cycle after the sample
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            fail_count       <= '0;
            checked_count    <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (samp_vld_q) begin
            checked_count <= checked_count + CNT_W'(1);
            if (!samp_f_q) begin
                if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
                if (!first_fail_valid) begin
                    first_fail_vec   <= samp_vec_q;
                    first_fail_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_formula_sweep_checker.sv
// Directed bench for formula_sweep_checker using three configurations.
// A: N_IN=4 LAT=1; B: N_IN=31 LAT=3; C: N_IN=4 LAT=2.
// Formula models are driven from bench-local state only.
module tb_formula_sweep_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Instance A: N_IN=4, SAMPLE_LAT=1
    logic       a_start = 1'b0, a_abort = 1'b0, a_mode = 1'b0, a_fmode = 1'b0;
    logic [3:0] a_seed = 4'd0;
    logic [7:0] a_limit = 8'd0;
    logic [3:0] a_vec, a_ffv;
    logic       a_f, a_busy, a_done, a_pass, a_aborted, a_ffvld;
    logic [7:0] a_fail, a_checked;

    // Formula A: true except for 0xA and 0xC when a_fmode is set
    always_comb a_f = a_fmode ? !((a_vec == 4'hA) || (a_vec == 4'hC)) : 1'b1;

    formula_sweep_checker #(.N_IN(4), .SAMPLE_LAT(1), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .lfsr_mode(a_mode),
        .seed(a_seed), .iter_limit(a_limit), .vec_out(a_vec), .f_out(a_f),
        .busy(a_busy), .done(a_done), .pass(a_pass), .aborted(a_aborted),
        .fail_count(a_fail), .checked_count(a_checked),
        .first_fail_vec(a_ffv), .first_fail_valid(a_ffvld)
    );

    // Instance B: N_IN=31, SAMPLE_LAT=3
    logic        b_start = 1'b0, b_abort = 1'b0, b_mode = 1'b0, b_fmode = 1'b0;
    logic [30:0] b_seed = 31'd0;
    logic [31:0] b_limit = 32'd0;
    logic [30:0] b_vec, b_ffv, b_v1, b_v2;
    logic        b_f, b_busy, b_done, b_pass, b_aborted, b_ffvld;
    logic [31:0] b_fail, b_checked;

    // Formula B is a two-register pipeline: output valid two cycles after its input
    always @(posedge clk) begin
        b_v1 <= b_vec;
        b_v2 <= b_v1;
    end
    always_comb b_f = b_fmode ? (b_v2 != 31'd4) : 1'b1;

    formula_sweep_checker #(.N_IN(31), .SAMPLE_LAT(3), .CNT_W(32)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .lfsr_mode(b_mode),
        .seed(b_seed), .iter_limit(b_limit), .vec_out(b_vec), .f_out(b_f),
        .busy(b_busy), .done(b_done), .pass(b_pass), .aborted(b_aborted),
        .fail_count(b_fail), .checked_count(b_checked),
        .first_fail_vec(b_ffv), .first_fail_valid(b_ffvld)
    );

    // Instance C: N_IN=4, SAMPLE_LAT=2, tautology model
    logic       c_start = 1'b0, c_abort = 1'b0, c_mode = 1'b0;
    logic [3:0] c_seed = 4'd0;
    logic [7:0] c_limit = 8'd0;
    logic [3:0] c_vec, c_ffv;
    logic       c_f, c_busy, c_done, c_pass, c_aborted, c_ffvld;
    logic [7:0] c_fail, c_checked;

    assign c_f = 1'b1;

    formula_sweep_checker #(.N_IN(4), .SAMPLE_LAT(2), .CNT_W(8)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .abort(c_abort), .lfsr_mode(c_mode),
        .seed(c_seed), .iter_limit(c_limit), .vec_out(c_vec), .f_out(c_f),
        .busy(c_busy), .done(c_done), .pass(c_pass), .aborted(c_aborted),
        .fail_count(c_fail), .checked_count(c_checked),
        .first_fail_vec(c_ffv), .first_fail_valid(c_ffvld)
    );

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({a_busy, a_done, a_pass, a_aborted, a_ffvld, a_vec, a_fail, a_checked, a_ffv} !== '0) begin
            failures++;
            $display("FAIL reset_a: got busy=%b done=%b pass=%b vec=%0h fail=%0d chk=%0d, want all 0",
                     a_busy, a_done, a_pass, a_vec, a_fail, a_checked);
        end
        checks++;
        if ({b_busy, b_done, b_pass, b_aborted, b_ffvld, b_vec, b_fail, b_checked, b_ffv} !== '0) begin
            failures++;
            $display("FAIL reset_b: got busy=%b done=%b vec=%0h chk=%0d, want all 0",
                     b_busy, b_done, b_vec, b_checked);
        end
        checks++;
        if ({c_busy, c_done, c_pass, c_aborted, c_ffvld, c_vec, c_fail, c_checked, c_ffv} !== '0) begin
            failures++;
            $display("FAIL reset_c: got busy=%b done=%b vec=%0h chk=%0d, want all 0",
                     c_busy, c_done, c_vec, c_checked);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Full 16-assignment exhaustive sweep on A; ext_start pulses start mid-run
    task automatic run_a_exhaustive(input bit ext_start, input int exp_fail,
                                    input logic [3:0] exp_ffv, input string tag);
        int cyc;
        a_mode = 1'b0; a_limit = 8'd0;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        cyc = 1;
        while (a_done !== 1'b1 && cyc < 40) begin
            if (cyc <= 16) begin
                checks++;
                if (a_vec !== 4'(cyc - 1)) begin
                    failures++;
                    $display("FAIL %s_order: cycle %0d vec=%0h want %0h", tag, cyc, a_vec, 4'(cyc - 1));
                end
            end
            if (cyc <= 17 && a_busy !== 1'b1) begin
                failures++;
                checks++;
                $display("FAIL %s_busy: cycle %0d busy=%b want 1", tag, cyc, a_busy);
            end
            a_start = ext_start && (cyc == 3);
            @(negedge clk);
            a_start = 1'b0;
            cyc++;
        end
        checks++;
        if (cyc != 18) begin
            failures++;
            $display("FAIL %s_done_cycle: got %0d want 18", tag, cyc);
        end
        checks++;
        if (a_checked !== 8'd16 || a_fail !== 8'(exp_fail)) begin
            failures++;
            $display("FAIL %s_counts: checked=%0d fail=%0d want 16/%0d", tag, a_checked, a_fail, exp_fail);
        end
        checks++;
        if (a_pass !== (exp_fail == 0) || a_aborted !== 1'b0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_status: pass=%b aborted=%b busy=%b want %b/0/0", tag, a_pass, a_aborted,
                     a_busy, exp_fail == 0);
        end
        checks++;
        if (a_ffvld !== (exp_fail != 0) || (exp_fail != 0 && a_ffv !== exp_ffv)) begin
            failures++;
            $display("FAIL %s_first_fail: valid=%b vec=%0h want %b/%0h", tag, a_ffvld, a_ffv,
                     exp_fail != 0, exp_ffv);
        end
        checks++;
        if (a_vec !== 4'h0) begin
            failures++;
            $display("FAIL %s_wrap: vec after sweep=%0h want 0", tag, a_vec);
        end
    endtask

    task automatic test_exhaustive;
        a_fmode = 1'b0;
        run_a_exhaustive(1'b0, 0, 4'h0, "exh");
    endtask

    task automatic test_fail_vectors;
        a_fmode = 1'b1;
        run_a_exhaustive(1'b1, 2, 4'hA, "failvec");
    endtask

    task automatic test_lfsr;
        int cyc;
        int zeros;
        b_mode = 1'b1; b_seed = 31'd0; b_limit = 32'd1000; b_fmode = 1'b0;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        cyc = 1;
        zeros = 0;
        while (b_done !== 1'b1 && cyc < 1100) begin
            if (cyc == 1) begin
                checks++;
                if (b_vec !== 31'd1) begin
                    failures++;
                    $display("FAIL lfsr_first: got %0h want 1", b_vec);
                end
            end
            if (cyc == 2) begin
                checks++;
                if (b_vec !== 31'd2) begin
                    failures++;
                    $display("FAIL lfsr_second: got %0h want 2", b_vec);
                end
            end
            if (cyc <= 1000 && b_vec == 31'd0) zeros++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (zeros != 0) begin
            failures++;
            $display("FAIL lfsr_zero: saw %0d zero vectors want 0", zeros);
        end
        checks++;
        if (cyc != 1004) begin
            failures++;
            $display("FAIL lfsr_done_cycle: got %0d want 1004", cyc);
        end
        checks++;
        if (b_checked !== 32'd1000 || b_pass !== 1'b1) begin
            failures++;
            $display("FAIL lfsr_counts: checked=%0d pass=%b want 1000/1", b_checked, b_pass);
        end
    endtask

    task automatic test_latency;
        int cyc;
        int drain;
        b_mode = 1'b0; b_limit = 32'd8; b_fmode = 1'b1;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        cyc = 1;
        drain = 0;
        while (b_done !== 1'b1 && cyc < 40) begin
            if (cyc == 5) begin
                checks++;
                if (b_vec !== 31'd4) begin
                    failures++;
                    $display("FAIL lat_fifth_vec: got %0h want 4", b_vec);
                end
            end
            if (cyc > 8 && b_busy === 1'b1) drain++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (drain != 3 || cyc != 12) begin
            failures++;
            $display("FAIL lat_drain: drain=%0d done_cycle=%0d want 3/12", drain, cyc);
        end
        checks++;
        if (b_ffvld !== 1'b1 || b_ffv !== 31'd4) begin
            failures++;
            $display("FAIL lat_first_fail: valid=%b vec=%0h want 1/4", b_ffvld, b_ffv);
        end
        checks++;
        if (b_fail !== 32'd1 || b_checked !== 32'd8 || b_pass !== 1'b0) begin
            failures++;
            $display("FAIL lat_counts: fail=%0d checked=%0d pass=%b want 1/8/0", b_fail, b_checked, b_pass);
        end
    endtask

    task automatic test_abort;
        int cyc;
        c_mode = 1'b0; c_limit = 8'd0;
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        cyc = 1;
        while (c_done !== 1'b1 && cyc < 40) begin
            // abort together with a start: abort must win
            c_abort = (cyc == 6);
            c_start = (cyc == 6);
            @(negedge clk);
            c_abort = 1'b0;
            c_start = 1'b0;
            cyc++;
        end
        checks++;
        if (cyc != 8) begin
            failures++;
            $display("FAIL abort_done_cycle: got %0d want 8", cyc);
        end
        checks++;
        if (c_checked !== 8'd5 || c_fail !== 8'd0) begin
            failures++;
            $display("FAIL abort_counts: checked=%0d fail=%0d want 5/0", c_checked, c_fail);
        end
        checks++;
        if (c_aborted !== 1'b1 || c_pass !== 1'b0 || c_busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_status: aborted=%b pass=%b busy=%b want 1/0/0", c_aborted, c_pass, c_busy);
        end
        checks++;
        if (c_vec !== 4'h5) begin
            failures++;
            $display("FAIL abort_vec_hold: got %0h want 5", c_vec);
        end
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        a_fmode = 1'b1; a_mode = 1'b0; a_limit = 8'd0;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (cyc = 1; cyc < 14; cyc++) @(negedge clk);
        checks++;
        if (a_ffvld !== 1'b1 || a_fail !== 8'd1 || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_pre: ffvld=%b fail=%0d busy=%b want 1/1/1", a_ffvld, a_fail, a_busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_busy, a_done, a_pass, a_aborted, a_ffvld, a_vec, a_fail, a_checked, a_ffv} !== '0) begin
            failures++;
            $display("FAIL midrun_reset: busy=%b done=%b vec=%0h fail=%0d chk=%0d want all 0",
                     a_busy, a_done, a_vec, a_fail, a_checked);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL midrun_idle: done=%b busy=%b want 0/0", a_done, a_busy);
        end
        a_fmode = 1'b0;
        run_a_exhaustive(1'b0, 0, 4'h0, "restart");
    endtask

    initial begin
        test_reset;
        test_exhaustive;
        test_fail_vectors;
        test_lfsr;
        test_latency;
        test_abort;
        test_reset_mid_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
